// File: rtl/frame_pkg.sv
// Shared definitions for the frame deframer: sync byte, CRC-8 polynomial,
// abort cause codes, FSM states and the byte-wise CRC update.
package frame_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY    = 8'h07;

  localparam logic [1:0] ERR_LEN = 2'd0;
  localparam logic [1:0] ERR_CRC = 2'd1;
  localparam logic [1:0] ERR_DEC = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHECK,
    DRAIN
  } state_t;

  // MSB-first, non-reflected CRC-8 over one byte, no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_buffer.sv
// Simple dual-port payload RAM: synchronous write, registered read.
module frame_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_deframer.sv
// Hunts SYNC-led frames in the decoded byte stream, checks length and CRC-8,
// buffers one payload and releases it on a valid/ready stream once accepted.
module frame_deframer
  import frame_pkg::*;
#(
  parameter int         MAX_LEN = 64,
  parameter int         TIMEOUT = 1024,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  input  logic       d_rdy,
  input  logic       d_err,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frm_ok,
  output logic       frm_err,
  output logic [1:0] err_code,
  output logic       drop,
  output logic       busy
);

  localparam int         AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    rd_idx_q, rd_idx_d;
  logic [7:0]    crc_q, crc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          frm_ok_q, frm_ok_d;
  logic          frm_err_q, frm_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          drop_q, drop_d;
  logic          wr_en, rd_en;
  logic [7:0]    rd_data;

  frame_buffer #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (idx_q[AW-1:0]),
    .wr_data (d),
    .rd_en   (rd_en),
    .rd_addr (rd_idx_q[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    crc_d       = crc_q;
    tmo_d       = tmo_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frm_ok_d    = 1'b0;
    frm_err_d   = 1'b0;
    err_code_d  = err_code_q;
    drop_d      = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;

    case (state_q)
      HUNT: begin
        if (d_rdy && d == SYNC) begin
          state_d = LEN;
          crc_d   = 8'h00;
          tmo_d   = '0;
          idx_d   = 8'h00;
        end
      end

      LEN, PAYLOAD, CHECK: begin
        // A decoder error wins over a simultaneous byte: the byte is never used.
        if (d_err) begin
          frm_err_d  = 1'b1;
          err_code_d = ERR_DEC;
          state_d    = HUNT;
        end else if (d_rdy) begin
          tmo_d = '0;
          case (state_q)
            LEN: begin
              if (d == 8'h00 || d > MAX_LEN8) begin
                frm_err_d  = 1'b1;
                err_code_d = ERR_LEN;
                state_d    = HUNT;
              end else begin
                len_d   = d;
                crc_d   = crc8_byte(crc_q, d);
                state_d = PAYLOAD;
              end
            end
            PAYLOAD: begin
              wr_en = 1'b1;
              idx_d = idx_q + 8'd1;
              crc_d = crc8_byte(crc_q, d);
              if (idx_q + 8'd1 == len_q) state_d = CHECK;
            end
            default: begin
              if (d == crc_q) begin
                frm_ok_d    = 1'b1;
                rd_idx_d    = 8'h00;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                state_d     = DRAIN;
              end else begin
                frm_err_d  = 1'b1;
                err_code_d = ERR_CRC;
                state_d    = HUNT;
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          frm_err_d  = 1'b1;
          err_code_d = ERR_TMO;
          state_d    = HUNT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      DRAIN: begin
        drop_d = d_rdy;
        // The RAM read register doubles as the output holding register, so
        // a read is only issued when the current beat leaves (or none is held).
        if (out_valid_q && out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = HUNT;
        end else if ((!out_valid_q || out_ready) && rd_idx_q < len_q) begin
          rd_en       = 1'b1;
          rd_idx_d    = rd_idx_q + 8'd1;
          out_valid_d = 1'b1;
          out_last_d  = (rd_idx_q == len_q - 8'd1);
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      len_q       <= 8'h00;
      idx_q       <= 8'h00;
      rd_idx_q    <= 8'h00;
      crc_q       <= 8'h00;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frm_ok_q    <= 1'b0;
      frm_err_q   <= 1'b0;
      err_code_q  <= 2'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      crc_q       <= crc_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frm_ok_q    <= frm_ok_d;
      frm_err_q   <= frm_err_d;
      err_code_q  <= err_code_d;
      drop_q      <= drop_d;
    end
  end

  assign out_data  = out_valid_q ? rd_data : 8'h00;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frm_ok    = frm_ok_q;
  assign frm_err   = frm_err_q;
  assign err_code  = err_code_q;
  assign drop      = drop_q;
  assign busy      = (state_q != HUNT);

endmodule
